tusca_uc: RTL and testbench
===========================

Name: tusca_uc

Overview:
- Control unit for the TUSCA datapath.
- Sequences the periodic measure/delay cycle. Triggers a DHT11 measurement, then waits for the result with a timeout and bounded retries. Then runs the inter-measurement delay counter.
- Arbitrates access for configuration reception: a pending config request is serviced only at a cycle boundary, never during a measurement.
- Drives the servo enable and exposes its state for debug.

Parameters:
- TIMEOUT_MEDIDA, 50_000_000: cycles allowed in AGUARDA_MEDIDA before a timeout.
- MAX_TENTATIVAS, 3: total measurement attempts before entering ERRO_MEDIDA (≥1).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low (0 = reset).
- iniciar  input  1  start/restart request; level, sampled per cycle.
- parar  input  1  stop request; level.
- config_req  input  1  configuration request (button level); rising edge latched.
- pronto_medida  input  1  measurement done, from datapath.
- pronto_config  input  1  configuration done, from datapath.
- erro_config  input  1  configuration error, from datapath.
- fim_delay  input  1  delay counter terminal count.
- medir_dht11  output  1  one-cycle measurement trigger.
- receber_config  output  1  one-cycle config-reception trigger.
- conta_delay  output  1  delay counter enable.
- zera_delay  output  1  delay counter synchronous clear.
- gira  output  1  servo enable.
- ativo  output  1  periodic cycle running.
- erro_medida  output  1  measurement failure indicator.
- erro_cfg_flag  output  1  sticky configuration-error flag.
- db_estado  output  4  current state code.

Behaviour:
- Reset (reset=0, async): state INICIAL. All outputs 0. Internal flags and counters cleared: config_pend, ativo, timeout counter, retry counter, config_req edge register.
- State codes: INICIAL=0, PREPARA=1, MEDE=2, AGUARDA_MEDIDA=3, ESPERA=4, CONFIGURA=5, AGUARDA_CONFIG=6, ERRO_MEDIDA=7. Codes 8-F are illegal and go to INICIAL on the next clock.
- Moore outputs, registered state; outputs are valid in the cycle the state is entered.
- config_pend:
  - Set on a config_req 0→1 edge, detected with a one-cycle registered copy.
  - Cleared in CONFIGURA.
  - If set and clear happen in the same cycle, set wins.
- INICIAL:
  - ativo=0.
  - config_pend=1 → CONFIGURA (this has priority over iniciar).
  - Otherwise iniciar=1 → ativo←1, retries←0, go to PREPARA.
- PREPARA: zera_delay=1; timeout counter←0; → MEDE.
- MEDE: medir_dht11=1 for exactly one cycle; → AGUARDA_MEDIDA.
- AGUARDA_MEDIDA (timeout counter increments each cycle):
  - pronto_medida=1 → ESPERA, retries←0. pronto_medida wins over a simultaneous timeout.
  - Counter = TIMEOUT_MEDIDA-1 without pronto_medida:
    - retries < MAX_TENTATIVAS-1 → retries++, go to PREPARA.
    - Otherwise → ERRO_MEDIDA.
  - parar is ignored here, so a measurement is never aborted.
- ESPERA: conta_delay=1. Priority order:
  - parar=1 → INICIAL, ativo←0.
  - fim_delay=1 and config_pend=1 → CONFIGURA.
  - fim_delay=1 → PREPARA.
  - Otherwise stay.
- CONFIGURA: receber_config=1 for one cycle; config_pend←0; → AGUARDA_CONFIG.
- AGUARDA_CONFIG:
  - pronto_config=1 or erro_config=1 → PREPARA if ativo=1, else INICIAL.
  - erro_config=1 sets erro_cfg_flag. If both arrive together, the flag is set and the single transition still occurs.
  - pronto_config=1 alone clears erro_cfg_flag.
  - No timeout.
- ERRO_MEDIDA:
  - erro_medida=1, gira=0, ativo stays 1.
  - parar=1 → INICIAL, ativo←0 (parar has priority).
  - Otherwise iniciar=1 → retries←0, go to PREPARA.
- gira=1 in states PREPARA, MEDE, AGUARDA_MEDIDA and ESPERA; 0 elsewhere.
- Widths:
  - Timeout counter is $clog2(TIMEOUT_MEDIDA) bits, wide enough to hold TIMEOUT_MEDIDA-1.
  - Retry counter is $clog2(MAX_TENTATIVAS+1) bits and never wraps.
- Reset mid-operation: immediate return to INICIAL. Any pulse currently asserted is cut off in that cycle.

Test Plan (TIMEOUT_MEDIDA=8, MAX_TENTATIVAS=2):
1. Release reset, iniciar=1 for one cycle → db_estado sequence 1, 2, 3. medir_dht11 high for exactly one cycle. gira=1 and ativo=1 from PREPARA onward.
2. In AGUARDA_MEDIDA, pulse pronto_medida on the 3rd cycle → ESPERA with conta_delay=1. Pulse fim_delay → PREPARA with zera_delay=1 for one cycle.
3. Never assert pronto_medida → after 8 cycles returns to PREPARA (retry 1). After another 8 cycles enters ERRO_MEDIDA with erro_medida=1 and gira=0. Pulse iniciar → PREPARA with erro_medida=0.
4. Raise config_req during AGUARDA_MEDIDA, then pronto_medida, then fim_delay → CONFIGURA and receber_config pulses once. Assert erro_config → erro_cfg_flag=1 and returns to PREPARA. A later config with pronto_config → flag clears.
5. In ESPERA, assert parar and fim_delay in the same cycle → INICIAL with ativo=0 and gira=0. Raise config_req in INICIAL → CONFIGURA; after pronto_config → INICIAL.
6. Assert reset=0 while in MEDE → all outputs 0 asynchronously and db_estado=0. Hold config_req high across reset release → no config is latched (edge only).

Source files
------------

// File: rtl/tusca_uc.sv
// TUSCA control unit: sequences the measure/delay cycle with timeout and retries,
// and admits pending configuration requests only at cycle boundaries.
module tusca_uc #(
  parameter int unsigned TIMEOUT_MEDIDA = 50_000_000,
  parameter int unsigned MAX_TENTATIVAS = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       parar,
  input  logic       config_req,
  input  logic       pronto_medida,
  input  logic       pronto_config,
  input  logic       erro_config,
  input  logic       fim_delay,
  output logic       medir_dht11,
  output logic       receber_config,
  output logic       conta_delay,
  output logic       zera_delay,
  output logic       gira,
  output logic       ativo,
  output logic       erro_medida,
  output logic       erro_cfg_flag,
  output logic [3:0] db_estado
);

  localparam int unsigned TW = (TIMEOUT_MEDIDA > 1) ? $clog2(TIMEOUT_MEDIDA) : 1;
  localparam int unsigned RW = $clog2(MAX_TENTATIVAS + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_MEDIDA - 1);
  localparam logic [RW-1:0] RET_LAST = RW'(MAX_TENTATIVAS - 1);

  typedef enum logic [3:0] {
    INICIAL        = 4'd0,
    PREPARA        = 4'd1,
    MEDE           = 4'd2,
    AGUARDA_MEDIDA = 4'd3,
    ESPERA         = 4'd4,
    CONFIGURA      = 4'd5,
    AGUARDA_CONFIG = 4'd6,
    ERRO_MEDIDA    = 4'd7
  } state_t;

  state_t          state_q, state_d;
  logic            cfg_req_q;
  logic            config_pend_q, config_pend_d;
  logic            ativo_q, ativo_d;
  logic            flag_q, flag_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [RW-1:0]   ret_q, ret_d;
  logic            medir_d, receber_d, conta_d, zera_d, gira_d, erro_medida_d;

  // Next state, bookkeeping and next-cycle Moore outputs
  always_comb begin
    state_d       = state_q;
    ativo_d       = ativo_q;
    flag_d        = flag_q;
    tmo_d         = tmo_q;
    ret_d         = ret_q;
    config_pend_d = config_pend_q;

    case (state_q)
      INICIAL: begin
        ativo_d = 1'b0;
        if (config_pend_q) begin
          state_d = CONFIGURA;
        end else if (iniciar) begin
          ativo_d = 1'b1;
          ret_d   = '0;
          state_d = PREPARA;
        end
      end
      PREPARA: begin
        tmo_d   = '0;
        state_d = MEDE;
      end
      MEDE: state_d = AGUARDA_MEDIDA;
      AGUARDA_MEDIDA: begin
        tmo_d = tmo_q + TW'(1);
        if (pronto_medida) begin
          ret_d   = '0;
          state_d = ESPERA;
        end else if (tmo_q == TMO_LAST) begin
          if (ret_q < RET_LAST) begin
            ret_d   = ret_q + RW'(1);
            state_d = PREPARA;
          end else begin
            state_d = ERRO_MEDIDA;
          end
        end
      end
      ESPERA: begin
        if (parar) begin
          ativo_d = 1'b0;
          state_d = INICIAL;
        end else if (fim_delay && config_pend_q) begin
          state_d = CONFIGURA;
        end else if (fim_delay) begin
          state_d = PREPARA;
        end
      end
      CONFIGURA: begin
        config_pend_d = 1'b0;
        state_d       = AGUARDA_CONFIG;
      end
      AGUARDA_CONFIG: begin
        if (erro_config) begin
          flag_d = 1'b1;
        end else if (pronto_config) begin
          flag_d = 1'b0;
        end
        if (pronto_config || erro_config) begin
          state_d = ativo_q ? PREPARA : INICIAL;
        end
      end
      ERRO_MEDIDA: begin
        if (parar) begin
          ativo_d = 1'b0;
          state_d = INICIAL;
        end else if (iniciar) begin
          ret_d   = '0;
          state_d = PREPARA;
        end
      end
      default: state_d = INICIAL;
    endcase

    // A new press wins over the clear in CONFIGURA
    if (config_req && !cfg_req_q) begin
      config_pend_d = 1'b1;
    end

    medir_d       = (state_d == MEDE);
    receber_d     = (state_d == CONFIGURA);
    conta_d       = (state_d == ESPERA);
    zera_d        = (state_d == PREPARA);
    erro_medida_d = (state_d == ERRO_MEDIDA);
    gira_d        = (state_d == PREPARA) || (state_d == MEDE) ||
                    (state_d == AGUARDA_MEDIDA) || (state_d == ESPERA);
  end

  // Edge register resets high so a button held through reset is not a new press
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= INICIAL;
      cfg_req_q      <= 1'b1;
      config_pend_q  <= 1'b0;
      ativo_q        <= 1'b0;
      flag_q         <= 1'b0;
      tmo_q          <= '0;
      ret_q          <= '0;
      medir_dht11    <= 1'b0;
      receber_config <= 1'b0;
      conta_delay    <= 1'b0;
      zera_delay     <= 1'b0;
      gira           <= 1'b0;
      erro_medida    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cfg_req_q      <= config_req;
      config_pend_q  <= config_pend_d;
      ativo_q        <= ativo_d;
      flag_q         <= flag_d;
      tmo_q          <= tmo_d;
      ret_q          <= ret_d;
      medir_dht11    <= medir_d;
      receber_config <= receber_d;
      conta_delay    <= conta_d;
      zera_delay     <= zera_d;
      gira           <= gira_d;
      erro_medida    <= erro_medida_d;
    end
  end

  assign ativo         = ativo_q;
  assign erro_cfg_flag = flag_q;
  assign db_estado     = 4'(state_q);

endmodule

// File: tb/tb_tusca_uc.sv
// Self-checking bench for tusca_uc: directed vector table, hand sequences for
// timeout/config/stop/reset corners, and randomized stimulus against a reference model.
module tb_tusca_uc;

  localparam int unsigned T = 8;
  localparam int unsigned M = 2;

  logic       clock, reset;
  logic       iniciar, parar, config_req, pronto_medida, pronto_config, erro_config, fim_delay;
  logic       medir_dht11, receber_config, conta_delay, zera_delay, gira, ativo;
  logic       erro_medida, erro_cfg_flag;
  logic [3:0] db_estado;
  logic [11:0] dut_vec;

  int errors = 0;
  int checks = 0;

  tusca_uc #(.TIMEOUT_MEDIDA(T), .MAX_TENTATIVAS(M)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .parar(parar),
    .config_req(config_req), .pronto_medida(pronto_medida),
    .pronto_config(pronto_config), .erro_config(erro_config), .fim_delay(fim_delay),
    .medir_dht11(medir_dht11), .receber_config(receber_config),
    .conta_delay(conta_delay), .zera_delay(zera_delay), .gira(gira), .ativo(ativo),
    .erro_medida(erro_medida), .erro_cfg_flag(erro_cfg_flag), .db_estado(db_estado)
  );

  assign dut_vec = {db_estado, medir_dht11, receber_config, conta_delay, zera_delay,
                    gira, ativo, erro_medida, erro_cfg_flag};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: state by name-code, counters as plain integers
  int m_st, m_tmo, m_ret;
  bit m_pend, m_cfgq, m_ativo, m_flag;

  task automatic model_reset();
    m_st = 0; m_tmo = 0; m_ret = 0;
    m_pend = 0; m_cfgq = 1; m_ativo = 0; m_flag = 0;
  endtask

  task automatic model_step(input bit ini, par, cfg, pm, pc, ec, fd);
    int nst = m_st;
    int ntmo = m_tmo;
    int nret = m_ret;
    bit nativo = m_ativo;
    bit nflag = m_flag;
    bit npend = m_pend;
    case (m_st)
      0: begin
        nativo = 0;
        if (m_pend) nst = 5;
        else if (ini) begin nst = 1; nativo = 1; nret = 0; end
      end
      1: begin nst = 2; ntmo = 0; end
      2: nst = 3;
      3: begin
        ntmo = m_tmo + 1;
        if (pm) begin nst = 4; nret = 0; end
        else if (m_tmo == T - 1) begin
          if (m_ret < M - 1) begin nret = m_ret + 1; nst = 1; end
          else nst = 7;
        end
      end
      4: begin
        if (par) begin nst = 0; nativo = 0; end
        else if (fd) nst = m_pend ? 5 : 1;
      end
      5: begin nst = 6; npend = 0; end
      6: begin
        if (ec) nflag = 1;
        else if (pc) nflag = 0;
        if (pc || ec) nst = m_ativo ? 1 : 0;
      end
      7: begin
        if (par) begin nst = 0; nativo = 0; end
        else if (ini) begin nst = 1; nret = 0; end
      end
      default: nst = 0;
    endcase
    if (cfg && !m_cfgq) npend = 1;
    m_st = nst; m_tmo = ntmo; m_ret = nret; m_ativo = nativo;
    m_flag = nflag; m_pend = npend; m_cfgq = cfg;
  endtask

  function automatic logic [11:0] model_vec();
    bit g = (m_st >= 1 && m_st <= 4);
    return {4'(m_st), m_st == 2, m_st == 5, m_st == 4, m_st == 1, g, m_ativo, m_st == 7, m_flag};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs, advance the model and DUT one clock, compare all outputs
  task automatic tick(input bit ini, par, cfg, pm, pc, ec, fd);
    iniciar = ini; parar = par; config_req = cfg; pronto_medida = pm;
    pronto_config = pc; erro_config = ec; fim_delay = fd;
    model_step(ini, par, cfg, pm, pc, ec, fd);
    @(posedge clock);
    #1;
    chk("model", 32'(dut_vec), 32'(model_vec()));
  endtask

  // Asynchronous reset in mid-cycle; outputs must clear without a clock edge
  task automatic do_reset();
    #2 reset = 1'b0;
    #1 chk("async_reset", 32'(dut_vec), 32'd0);
    model_reset();
    @(posedge clock);
    #1 reset = 1'b1;
  endtask

  typedef struct {
    logic [6:0]  in;   // {ini, par, cfg, pm, pc, ec, fd}
    logic [11:0] exp;  // {state, medir, receber, conta, zera, gira, ativo, erro_m, erro_cfg}
  } vec_t;

  vec_t tbl [10];

  initial begin
    reset = 1'b0;
    iniciar = 0; parar = 0; config_req = 0; pronto_medida = 0;
    pronto_config = 0; erro_config = 0; fim_delay = 0;
    model_reset();
    @(posedge clock); @(posedge clock); #1;
    chk("reset_state", 32'(dut_vec), 32'd0);
    reset = 1'b1;

    // Start, measurement completes on the 3rd wait cycle, delay ends
    tbl[0] = '{7'b1000000, {4'h1, 8'b00011100}};
    tbl[1] = '{7'b0000000, {4'h2, 8'b10001100}};
    tbl[2] = '{7'b0000000, {4'h3, 8'b00001100}};
    tbl[3] = '{7'b0000000, {4'h3, 8'b00001100}};
    tbl[4] = '{7'b0000000, {4'h3, 8'b00001100}};
    tbl[5] = '{7'b0001000, {4'h4, 8'b00101100}};
    tbl[6] = '{7'b0000000, {4'h4, 8'b00101100}};
    tbl[7] = '{7'b0000001, {4'h1, 8'b00011100}};
    tbl[8] = '{7'b0000000, {4'h2, 8'b10001100}};
    tbl[9] = '{7'b0000000, {4'h3, 8'b00001100}};
    for (int i = 0; i < 10; i++) begin
      tick(tbl[i].in[6], tbl[i].in[5], tbl[i].in[4], tbl[i].in[3],
           tbl[i].in[2], tbl[i].in[1], tbl[i].in[0]);
      chk($sformatf("table[%0d]", i), 32'(dut_vec), 32'(tbl[i].exp));
    end

    // Timeout, one retry, then measurement error
    for (int i = 0; i < 7; i++) tick(0, 0, 0, 0, 0, 0, 0);
    chk("still_waiting", 32'(db_estado), 32'd3);
    tick(0, 0, 0, 0, 0, 0, 0);
    chk("timeout_retry", 32'(db_estado), 32'd1);
    tick(0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) tick(0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0);
    chk("erro_state", 32'(db_estado), 32'd7);
    chk("erro_flags", 32'({erro_medida, gira, ativo}), 32'b101);
    tick(1, 0, 0, 0, 0, 0, 0);
    chk("erro_restart", 32'({db_estado, erro_medida}), 32'({4'h1, 1'b0}));

    // Config request during a measurement is deferred to the end of delay
    tick(0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0, 0);
    chk("cfg_not_during_meas", 32'(db_estado), 32'd3);
    tick(0, 0, 0, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 1);
    chk("cfg_recv_pulse", 32'({db_estado, receber_config}), 32'({4'h5, 1'b1}));
    tick(0, 0, 0, 0, 0, 0, 0);
    chk("cfg_recv_once", 32'({db_estado, receber_config}), 32'({4'h6, 1'b0}));
    tick(0, 0, 0, 0, 0, 1, 0);
    chk("cfg_err_flag", 32'({db_estado, erro_cfg_flag}), 32'({4'h1, 1'b1}));
    tick(0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1, 0, 0);
    chk("cfg_flag_clear", 32'({db_estado, erro_cfg_flag}), 32'({4'h1, 1'b0}));

    // Stop beats delay end; config from idle returns to idle
    tick(0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 0, 1);
    chk("parar_wins", 32'({db_estado, ativo, gira}), 32'({4'h0, 2'b00}));
    tick(0, 0, 1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0);
    chk("idle_cfg", 32'(db_estado), 32'd5);
    tick(0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1, 0, 0);
    chk("idle_cfg_return", 32'({db_estado, ativo}), 32'({4'h0, 1'b0}));

    // Reset while in MEDE, config_req held across release
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0);
    chk("in_mede", 32'({db_estado, medir_dht11}), 32'({4'h2, 1'b1}));
    config_req = 1'b1;
    do_reset();
    tick(0, 0, 1, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0, 0);
    chk("no_cfg_after_reset", 32'(db_estado), 32'd0);
    tick(0, 0, 0, 0, 0, 0, 0);

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        tick($urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
             $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
             $urandom_range(0, 3) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
